pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Next-generation fetch PC generator. Replaces the plain write-enabled PC register.
//   Holds the current fetch PC and offers it to the fetch stage over a valid/ready handshake.
//   Selects the next PC by fixed priority: trap vector, mret return, branch/jump redirect,
//   sequential increment (4, or 2 for compressed).
//   Adds a post-reset boot hold, a debug halt mode, and branch-target misalignment reporting.
// PARAMETERS
//   XLEN         32            PC / address width
//   RESET_PC     32'h4000_0000 PC value loaded on reset
//   C_EXT        0             1: 16-bit alignment and 2-byte increments allowed; 0: 32-bit only
//   BOOT_CYCLES  4             cycles held in BOOT after reset release; 0 = fetch immediately
// PORTS
//   clk_i              in   1     clock, rising edge
//   rst_ni             in   1     asynchronous active-low reset
//   fetch_valid_o      out  1     fetch_pc_o is a valid fetch request
//   fetch_ready_i      in   1     fetch stage accepts request (fire = valid & ready)
//   fetch_pc_o         out  XLEN  current fetch PC
//   instr_compressed_i in   1     instruction at fetch_pc_o is 16-bit; used only when C_EXT=1
//   stall_i            in   1     pipeline stall; suppresses fetch_valid_o
//   trap_i             in   1     take trap
//   trap_vec_i         in   XLEN  trap target (mtvec base)
//   mret_i             in   1     return from trap
//   mepc_i             in   XLEN  mret target
//   br_taken_i         in   1     branch/jump redirect
//   br_target_i        in   XLEN  redirect target
//   halt_req_i         in   1     debug halt request (level)
//   halted_o           out  1     block is in HALT
//   redirect_o         out  1     1-cycle pulse: PC was redirected on the previous edge
//   misaligned_o       out  1     1-cycle pulse: branch target rejected as misaligned
//   misaligned_addr_o  out  XLEN  offending target; valid while misaligned_o=1
// BEHAVIOUR
//   Reset (async, rst_ni=0) drives all state and outputs immediately:
//   - pc=RESET_PC, cnt=0, fetch_valid_o=0, halted_o=0, redirect_o=0, misaligned_o=0,
//     misaligned_addr_o=0.
//   - State is BOOT, or RUN if BOOT_CYCLES=0.
//   Reset mid-operation aborts any pending request; there is no memory of it.
//   States:
//   - BOOT: cnt increments each cycle; at cnt==BOOT_CYCLES-1 go to RUN. fetch_valid_o=0.
//     trap/mret/branch/halt are ignored.
//   - RUN: fetch_valid_o = ~stall_i. halt_req_i=1 -> HALT next cycle.
//     If fire and halt coincide, the fire still advances the PC.
//   - HALT: fetch_valid_o=0, halted_o=1. halt_req_i=0 -> RUN next cycle.
//     Redirects are still applied to pc.
//   Next pc (RUN/HALT), priority high->low, registered on the clock edge:
//     1. trap_i:      pc <= trap_vec_i with low bits cleared ([0]; also [1] if C_EXT=0).
//     2. mret_i:      pc <= mepc_i, same masking.
//     3. br_taken_i:  pc <= br_target_i if aligned. Aligned means target[0]==0 when C_EXT=1,
//                     or target[1:0]==0 when C_EXT=0.
//                     If misaligned: pc holds, misaligned_o=1 and misaligned_addr_o=br_target_i
//                     on the next cycle.
//     4. fire:        pc <= pc + ((C_EXT && instr_compressed_i) ? 2 : 4). Modulo 2^XLEN;
//                     wraps from all-ones region to 0.
//     5. otherwise pc holds.
//   Handshake:
//   - fetch_pc_o is stable while fetch_valid_o=1 and not fired.
//   - The sole exception is a redirect (priorities 1-3 accepted). The redirect replaces pc and
//     raises redirect_o for one cycle so fetch discards the old request.
//   - A redirect in the same cycle as a fire wins; no increment is applied.
//   Lower-priority redirect inputs asserted together with a higher one are dropped, not queued.
//   Latency: any accepted redirect appears on fetch_pc_o one cycle later.
//   That PC is offered with fetch_valid_o=1 if in RUN and stall_i=0.
// TESTING
//   1. Reset, BOOT_CYCLES=4, fetch_ready_i=1 -> valid first rises 4 cycles after rst_ni release.
//      fetch_pc_o then steps 0x4000_0000, 0x4000_0004, 0x4000_0008.
//   2. C_EXT=1, instr_compressed_i=1 at pc 0x4000_0010 with fire -> next pc 0x4000_0012.
//      C_EXT=0 ignores instr_compressed_i -> next pc 0x4000_0014.
//   3. trap_i, mret_i and br_taken_i asserted in one cycle, trap_vec_i=0x8000_0103
//      -> pc=0x8000_0100 (C_EXT=0), redirect_o pulses, mret and branch are dropped.
//   4. br_target_i=0x4000_0102, C_EXT=0 -> pc holds, misaligned_o=1 for 1 cycle,
//      misaligned_addr_o=0x4000_0102, no redirect_o.
//   5. fetch_ready_i=0 with stall toggling -> fetch_pc_o stable.
//      halt_req_i -> halted_o next cycle, valid=0. A branch in HALT updates pc.
//      Release halt -> fetch resumes at the branch target.
//   6. pc=0xFFFF_FFFC, fire -> pc=0x0000_0000.
//      rst_ni asserted mid-request -> outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC generator: holds the fetch PC, offers it over valid/ready, and selects the next PC
// from trap, mret, branch redirect or sequential increment, with boot hold and debug halt.
module pc_gen #(
  parameter int unsigned         XLEN        = 32,
  parameter logic [XLEN-1:0]     RESET_PC    = 32'h4000_0000,
  parameter bit                  C_EXT       = 1'b0,
  parameter int unsigned         BOOT_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] fetch_pc_o,
  input  logic            instr_compressed_i,
  input  logic            stall_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            halt_req_i,
  output logic            halted_o,
  output logic            redirect_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] misaligned_addr_o
);

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  localparam logic [1:0] StReset = (BOOT_CYCLES == 0) ? StRun : StBoot;

  localparam int unsigned   CntW    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = (BOOT_CYCLES > 0) ? CntW'(BOOT_CYCLES - 1) : '0;

  // Trap/mret targets are forced to instruction alignment rather than rejected.
  localparam logic [XLEN-1:0] AlignMask = C_EXT ? ~XLEN'(1) : ~XLEN'(3);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            redirect_q, redirect_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic            fire;
  logic            br_aligned;
  logic [XLEN-1:0] pc_inc;

  // rst_ni gating keeps valid low during reset even when the reset state is RUN.
  assign fetch_valid_o     = rst_ni & (state_q == StRun) & ~stall_i;
  assign fetch_pc_o        = pc_q;
  assign halted_o          = (state_q == StHalt);
  assign redirect_o        = redirect_q;
  assign misaligned_o      = mis_q;
  assign misaligned_addr_o = mis_addr_q;

  assign fire       = fetch_valid_o & fetch_ready_i;
  assign br_aligned = C_EXT ? ~br_target_i[0] : (br_target_i[1:0] == 2'b00);
  assign pc_inc     = (C_EXT && instr_compressed_i) ? XLEN'(2) : XLEN'(4);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;

    case (state_q)
      StBoot: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StRun;
      end
      StRun:   if (halt_req_i) state_d = StHalt;
      StHalt:  if (!halt_req_i) state_d = StRun;
      default: state_d = StReset;
    endcase

    if (state_q == StRun || state_q == StHalt) begin
      if (trap_i) begin
        pc_d       = trap_vec_i & AlignMask;
        redirect_d = 1'b1;
      end else if (mret_i) begin
        pc_d       = mepc_i & AlignMask;
        redirect_d = 1'b1;
      end else if (br_taken_i) begin
        if (br_aligned) begin
          pc_d       = br_target_i;
          redirect_d = 1'b1;
        end else begin
          mis_d      = 1'b1;
          mis_addr_d = br_target_i;
        end
      end else if (fire) begin
        pc_d = pc_q + pc_inc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StReset;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with C_EXT=0 and one with C_EXT=1 on shared stimulus.
module tb_pc_gen;

  localparam logic [31:0] ResetPc = 32'h4000_0000;

  logic        clk;
  logic        rst_n;
  logic        ready, compressed, stall, trap, mret, br, halt;
  logic [31:0] trap_vec, mepc, br_tgt;

  logic        v0, h0, r0, m0;
  logic [31:0] pc0, ma0;
  logic        v1, h1, r1, m1;
  logic [31:0] pc1, ma1;

  int tests;
  int fails;

  pc_gen #(.C_EXT(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .fetch_valid_o(v0), .fetch_ready_i(ready),
    .fetch_pc_o(pc0), .instr_compressed_i(compressed), .stall_i(stall), .trap_i(trap),
    .trap_vec_i(trap_vec), .mret_i(mret), .mepc_i(mepc), .br_taken_i(br),
    .br_target_i(br_tgt), .halt_req_i(halt), .halted_o(h0), .redirect_o(r0),
    .misaligned_o(m0), .misaligned_addr_o(ma0)
  );

  pc_gen #(.C_EXT(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .fetch_valid_o(v1), .fetch_ready_i(ready),
    .fetch_pc_o(pc1), .instr_compressed_i(compressed), .stall_i(stall), .trap_i(trap),
    .trap_vec_i(trap_vec), .mret_i(mret), .mepc_i(mepc), .br_taken_i(br),
    .br_target_i(br_tgt), .halt_req_i(halt), .halted_o(h1), .redirect_o(r1),
    .misaligned_o(m1), .misaligned_addr_o(ma1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b1; compressed = 1'b0; stall = 1'b0; trap = 1'b0; mret = 1'b0;
    br = 1'b0; halt = 1'b0; trap_vec = '0; mepc = '0; br_tgt = '0;
    tick();
    tests++;
    if (pc0 !== ResetPc) begin fails++; $display("FAIL reset_pc: got %h want %h", pc0, ResetPc); end
    tests++;
    if ({v0, h0, r0, m0} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {v0, h0, r0, m0});
    end
    tests++;
    if (ma0 !== 32'h0) begin fails++; $display("FAIL reset_maddr: got %h want 0", ma0); end
  endtask

  task automatic test_boot();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (v0 !== 1'b0) begin fails++; $display("FAIL boot_hold%0d: got %b want 0", i, v0); end
      tick();
    end
    tests++;
    if (v0 !== 1'b1 || pc0 !== 32'h4000_0000) begin
      fails++; $display("FAIL boot_first: got v=%b pc=%h want v=1 pc=40000000", v0, pc0);
    end
    tick();
    tests++;
    if (pc0 !== 32'h4000_0004) begin fails++; $display("FAIL seq1: got %h want 40000004", pc0); end
    tick();
    tests++;
    if (pc0 !== 32'h4000_0008) begin fails++; $display("FAIL seq2: got %h want 40000008", pc0); end
    ready = 1'b0;
  endtask

  task automatic test_compressed();
    br = 1'b1; br_tgt = 32'h4000_0010;
    tick();
    br = 1'b0;
    tests++;
    if (pc0 !== 32'h4000_0010 || pc1 !== 32'h4000_0010 || r0 !== 1'b1) begin
      fails++; $display("FAIL br_to_10: got pc0=%h pc1=%h r=%b want 40000010 40000010 1",
                        pc0, pc1, r0);
    end
    compressed = 1'b1; ready = 1'b1;
    tick();
    compressed = 1'b0; ready = 1'b0;
    tests++;
    if (pc1 !== 32'h4000_0012) begin fails++; $display("FAIL cext_inc2: got %h want 40000012", pc1); end
    tests++;
    if (pc0 !== 32'h4000_0014) begin fails++; $display("FAIL nocext_inc4: got %h want 40000014", pc0); end
    tests++;
    if (r0 !== 1'b0) begin fails++; $display("FAIL redirect_one_cycle: got %b want 0", r0); end
  endtask

  task automatic test_priority();
    trap = 1'b1; trap_vec = 32'h8000_0103; mret = 1'b1; mepc = 32'h1234_5670;
    br = 1'b1; br_tgt = 32'h2000_0000; ready = 1'b1;
    tick();
    trap = 1'b0; mret = 1'b0; br = 1'b0; ready = 1'b0;
    tests++;
    if (pc0 !== 32'h8000_0100) begin fails++; $display("FAIL trap_pc: got %h want 80000100", pc0); end
    tests++;
    if (pc1 !== 32'h8000_0102) begin fails++; $display("FAIL trap_pc_cext: got %h want 80000102", pc1); end
    tests++;
    if (r0 !== 1'b1 || m0 !== 1'b0) begin
      fails++; $display("FAIL trap_flags: got r=%b m=%b want r=1 m=0", r0, m0);
    end
    tick();
    tests++;
    if (r0 !== 1'b0 || pc0 !== 32'h8000_0100) begin
      fails++; $display("FAIL trap_after: got r=%b pc=%h want r=0 pc=80000100", r0, pc0);
    end
    mret = 1'b1; mepc = 32'h4000_0087; br = 1'b1; br_tgt = 32'h2000_0000;
    tick();
    mret = 1'b0; br = 1'b0;
    tests++;
    if (pc0 !== 32'h4000_0084 || r0 !== 1'b1) begin
      fails++; $display("FAIL mret_pc: got pc=%h r=%b want 40000084 1", pc0, r0);
    end
    trap = 1'b1; trap_vec = 32'h8000_0100;
    tick();
    trap = 1'b0;
  endtask

  task automatic test_misaligned();
    br = 1'b1; br_tgt = 32'h4000_0102;
    tick();
    br = 1'b0;
    tests++;
    if (pc0 !== 32'h8000_0100) begin fails++; $display("FAIL mis_hold: got %h want 80000100", pc0); end
    tests++;
    if (m0 !== 1'b1 || ma0 !== 32'h4000_0102) begin
      fails++; $display("FAIL mis_flag: got m=%b addr=%h want 1 40000102", m0, ma0);
    end
    tests++;
    if (r0 !== 1'b0) begin fails++; $display("FAIL mis_noredir: got %b want 0", r0); end
    tests++;
    if (pc1 !== 32'h4000_0102 || m1 !== 1'b0) begin
      fails++; $display("FAIL cext_aligned: got pc=%h m=%b want 40000102 0", pc1, m1);
    end
    tick();
    tests++;
    if (m0 !== 1'b0) begin fails++; $display("FAIL mis_pulse: got %b want 0", m0); end
  endtask

  task automatic test_halt();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stall = i[0];
      #1;
      tests++;
      if (pc0 !== 32'h8000_0100 || v0 !== ~stall) begin
        fails++; $display("FAIL stall_stable%0d: got pc=%h v=%b want 80000100 %b", i, pc0, v0, ~stall);
      end
      tick();
    end
    stall = 1'b0; halt = 1'b1;
    tick();
    tests++;
    if (h0 !== 1'b1 || v0 !== 1'b0) begin
      fails++; $display("FAIL halt_enter: got h=%b v=%b want 1 0", h0, v0);
    end
    br = 1'b1; br_tgt = 32'h4000_0200;
    tick();
    br = 1'b0;
    tests++;
    if (pc0 !== 32'h4000_0200 || h0 !== 1'b1 || v0 !== 1'b0) begin
      fails++; $display("FAIL halt_branch: got pc=%h h=%b v=%b want 40000200 1 0", pc0, h0, v0);
    end
    halt = 1'b0;
    tick();
    tests++;
    if (h0 !== 1'b0 || v0 !== 1'b1 || pc0 !== 32'h4000_0200) begin
      fails++; $display("FAIL halt_exit: got h=%b v=%b pc=%h want 0 1 40000200", h0, v0, pc0);
    end
  endtask

  task automatic test_wrap();
    br = 1'b1; br_tgt = 32'hFFFF_FFFC;
    tick();
    br = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
    tests++;
    if (pc0 !== 32'h0000_0000) begin fails++; $display("FAIL wrap: got %h want 00000000", pc0); end
  endtask

  task automatic test_reset_mid();
    br = 1'b1; br_tgt = 32'h4000_0300; ready = 1'b1;
    tick();
    br = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (pc0 !== ResetPc || v0 !== 1'b0 || r0 !== 1'b0 || h0 !== 1'b0) begin
      fails++; $display("FAIL reset_async: got pc=%h v=%b r=%b h=%b want 40000000 0 0 0",
                        pc0, v0, r0, h0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (v0 !== 1'b0 || pc0 !== ResetPc) begin
      fails++; $display("FAIL reset_reboot: got v=%b pc=%h want 0 40000000", v0, pc0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_boot();
    test_compressed();
    test_priority();
    test_misaligned();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
